id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register feeding the integer ALU (OP1/OP2/ALU_OP) and the MEM stage controls.
//  Resolves operands at capture: forwarding from EX and MEM, and PC/immediate operand select.
//  Detects load-use hazards, inserts bubbles and honours stall/flush from the hazard unit.
//  Register file is write-through, so the WB stage needs no forwarding path here.
// PARAMETERS
//  XLEN     32  datapath width
//  RA_W     5   register address width
//  ALUOP_W  5   ALU operation code width (ALU encoding: 0 ADD ... 16 FORWARD)
// PORTS
//  CLK             in   1       clock, rising edge
//  RESET           in   1       async active-high reset
//  STALL           in   1       hold all stage registers (downstream busy)
//  FLUSH           in   1       squash: next stage content is a bubble
//  ID_VALID        in   1       decode slot holds a real instruction
//  ID_PC           in   XLEN    PC of decoded instruction
//  ID_DATA1/2      in   XLEN    register file read data rs1/rs2
//  ID_IMM          in   XLEN    sign-extended immediate
//  ID_RS1/2, ID_RD in   RA_W    source/destination register numbers
//  ID_ALU_OP       in   ALUOP_W ALU operation code
//  ID_OP1_SEL      in   1       0: rs1 value, 1: PC
//  ID_OP2_SEL      in   1       0: rs2 value, 1: immediate
//  ID_REG_WRITE    in   1       writes rd
//  ID_MEM_READ     in   1       load
//  ID_MEM_WRITE    in   1       store
//  EX_RESULT       in   XLEN    ALU RESULT of instruction currently in EX
//  MEM_RD          in   RA_W    rd of instruction in MEM
//  MEM_REG_WRITE   in   1       MEM instruction writes rd (valid-qualified upstream)
//  MEM_DATA        in   XLEN    final MEM result (load data or ALU result)
//  LOAD_USE_STALL  out  1       combinational; freeze PC and IF/ID this cycle
//  EX_VALID        out  1       stage holds a real instruction
//  EX_PC           out  XLEN    registered PC
//  EX_OP1, EX_OP2  out  XLEN    ALU operands
//  EX_ALU_OP       out  ALUOP_W ALU operation code
//  EX_STORE_DATA   out  XLEN    forwarded rs2 value (store data)
//  EX_RD           out  RA_W    destination register
//  EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE  out 1 each  registered controls
// BEHAVIOUR
//  - Reset (async): all outputs and registers 0; EX_VALID=0; LOAD_USE_STALL=0 while RESET.
//  - Latency: 1 cycle ID->EX. Register update priority per rising edge:
//    FLUSH > STALL > load-use bubble > normal capture.
//  - FLUSH: load bubble (all registered outputs 0), even if STALL is also high.
//  - STALL (no FLUSH): every register holds its value; forwarding is not re-evaluated.
//  - Load-use: LOAD_USE_STALL = EX_VALID & EX_MEM_READ & EX_RD!=0 & ID_VALID & ~FLUSH &
//    ((ID_RS1==EX_RD & ~ID_OP1_SEL) | ID_RS2==EX_RD). If set (no STALL): load bubble.
//    The ID instruction is re-presented next cycle and captured normally.
//  - Forwarding, per source r in {rs1, rs2}:
//    EX hit (EX_VALID & EX_REG_WRITE & ~EX_MEM_READ & EX_RD==r) -> EX_RESULT;
//    else MEM hit (MEM_REG_WRITE & MEM_RD==r) -> MEM_DATA; else ID_DATA.
//    r==0 never forwards; the value is then taken as 0 regardless of ID_DATA.
//  - EX_OP1 = OP1_SEL ? ID_PC : fwd(rs1). EX_OP2 = OP2_SEL ? ID_IMM : fwd(rs2).
//    EX_STORE_DATA = fwd(rs2) always.
//  - ID_VALID=0 on capture: load bubble (controls gated to 0 so no spurious writes).
//  - Bubble: EX_VALID, REG_WRITE, MEM_READ, MEM_WRITE, ALU_OP, RD, operands, PC all 0.
//  - RESET mid-stall or mid-flush: state cleared immediately; the first capture follows deassertion.
// TESTING
//  - Reset: RESET=1 with random inputs -> all outputs 0; release, ID_VALID=1 ADD x3,x1,x2
//    (DATA1=5, DATA2=7) -> next cycle EX_OP1=5, EX_OP2=7, EX_RD=3, EX_VALID=1.
//  - EX forward: EX holds rd=3 with EX_RESULT=12; ID rs1=3, DATA1=0 -> EX_OP1=12.
//    With MEM_RD=3, MEM_DATA=99 also present -> still 12 (EX priority).
//  - x0: EX_RD=0, REG_WRITE=1, EX_RESULT=0xFFFF; ID rs1=0 -> EX_OP1=0. No load-use stall.
//  - Load-use: EX load rd=5; ID rs2=5 -> LOAD_USE_STALL=1, next EX_VALID=0.
//    ID held; following cycle MEM_RD=5, MEM_DATA=0x55 -> EX_OP2=0x55.
//  - Stall/flush: STALL=1 for 3 cycles -> outputs unchanged. STALL=1, FLUSH=1 -> bubble.
//    OP1_SEL=1, PC=0x100, OP2_SEL=1, IMM=-4 -> EX_OP1=0x100, EX_OP2=0xFFFFFFFC.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves forwarded operands and PC/immediate selection at capture,
// detects load-use hazards, and applies flush/stall/bubble priority to the EX-stage state.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               STALL,
  input  logic               FLUSH,
  input  logic               ID_VALID,
  input  logic [XLEN-1:0]    ID_PC,
  input  logic [XLEN-1:0]    ID_DATA1,
  input  logic [XLEN-1:0]    ID_DATA2,
  input  logic [XLEN-1:0]    ID_IMM,
  input  logic [RA_W-1:0]    ID_RS1,
  input  logic [RA_W-1:0]    ID_RS2,
  input  logic [RA_W-1:0]    ID_RD,
  input  logic [ALUOP_W-1:0] ID_ALU_OP,
  input  logic               ID_OP1_SEL,
  input  logic               ID_OP2_SEL,
  input  logic               ID_REG_WRITE,
  input  logic               ID_MEM_READ,
  input  logic               ID_MEM_WRITE,
  input  logic [XLEN-1:0]    EX_RESULT,
  input  logic [RA_W-1:0]    MEM_RD,
  input  logic               MEM_REG_WRITE,
  input  logic [XLEN-1:0]    MEM_DATA,
  output logic               LOAD_USE_STALL,
  output logic               EX_VALID,
  output logic [XLEN-1:0]    EX_PC,
  output logic [XLEN-1:0]    EX_OP1,
  output logic [XLEN-1:0]    EX_OP2,
  output logic [ALUOP_W-1:0] EX_ALU_OP,
  output logic [XLEN-1:0]    EX_STORE_DATA,
  output logic [RA_W-1:0]    EX_RD,
  output logic               EX_REG_WRITE,
  output logic               EX_MEM_READ,
  output logic               EX_MEM_WRITE
);

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    op1;
    logic [XLEN-1:0]    op2;
    logic [XLEN-1:0]    sd;
    logic [ALUOP_W-1:0] alu_op;
    logic [RA_W-1:0]    rd;
    logic               rw;
    logic               mr;
    logic               mw;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d;
  logic [XLEN-1:0] fwd1, fwd2;
  logic ex_fwd_ok, ex_hit1, ex_hit2, mem_hit1, mem_hit2, lu_hit;

  // A load in EX has no data yet, so it never forwards from here; that case is the load-use bubble.
  assign ex_fwd_ok = ex_q.valid & ex_q.rw & ~ex_q.mr;
  assign ex_hit1   = ex_fwd_ok & (ex_q.rd == ID_RS1);
  assign ex_hit2   = ex_fwd_ok & (ex_q.rd == ID_RS2);
  assign mem_hit1  = MEM_REG_WRITE & (MEM_RD == ID_RS1);
  assign mem_hit2  = MEM_REG_WRITE & (MEM_RD == ID_RS2);

  assign fwd1 = (ID_RS1 == '0) ? '0 : ex_hit1 ? EX_RESULT : mem_hit1 ? MEM_DATA : ID_DATA1;
  assign fwd2 = (ID_RS2 == '0) ? '0 : ex_hit2 ? EX_RESULT : mem_hit2 ? MEM_DATA : ID_DATA2;

  // rs1 is irrelevant when operand 1 comes from the PC; rs2 still feeds store data.
  assign lu_hit = ((ID_RS1 == ex_q.rd) & ~ID_OP1_SEL) | (ID_RS2 == ex_q.rd);
  assign LOAD_USE_STALL = ~RESET & ex_q.valid & ex_q.mr & (ex_q.rd != '0) &
                          ID_VALID & ~FLUSH & lu_hit;

  always_comb begin
    ex_d = ex_q;
    if (FLUSH) begin
      ex_d = '0;
    end else if (STALL) begin
      ex_d = ex_q;
    end else if (LOAD_USE_STALL || !ID_VALID) begin
      ex_d = '0;
    end else begin
      ex_d.valid  = 1'b1;
      ex_d.pc     = ID_PC;
      ex_d.op1    = ID_OP1_SEL ? ID_PC : fwd1;
      ex_d.op2    = ID_OP2_SEL ? ID_IMM : fwd2;
      ex_d.sd     = fwd2;
      ex_d.alu_op = ID_ALU_OP;
      ex_d.rd     = ID_RD;
      ex_d.rw     = ID_REG_WRITE;
      ex_d.mr     = ID_MEM_READ;
      ex_d.mw     = ID_MEM_WRITE;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign EX_VALID      = ex_q.valid;
  assign EX_PC         = ex_q.pc;
  assign EX_OP1        = ex_q.op1;
  assign EX_OP2        = ex_q.op2;
  assign EX_ALU_OP     = ex_q.alu_op;
  assign EX_STORE_DATA = ex_q.sd;
  assign EX_RD         = ex_q.rd;
  assign EX_REG_WRITE  = ex_q.rw;
  assign EX_MEM_READ   = ex_q.mr;
  assign EX_MEM_WRITE  = ex_q.mw;

endmodule
